// File: rtl/multicycle_control_if.sv
// Control-unit bundle: memory handshake in, datapath strobes and ALU
// controls out.
interface multicycle_control_if;
    logic [15:0] instr;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src_jump;
    logic        reg_write;
    logic        reg_dst_rd;
    logic        mem_to_reg;
    logic        alu_src_imm;
    logic [3:0]  aluop;
    logic [5:0]  funct;
    logic        wwd_valid;
    logic        halted;
    logic [15:0] num_inst;

    modport master (
        input  instr, mem_ready,
        output mem_read, mem_write, ir_write, pc_write, pc_src_jump,
        output reg_write, reg_dst_rd, mem_to_reg, alu_src_imm,
        output aluop, funct, wwd_valid, halted, num_inst
    );

    modport slave (
        output instr, mem_ready,
        input  mem_read, mem_write, ir_write, pc_write, pc_src_jump,
        input  reg_write, reg_dst_rd, mem_to_reg, alu_src_imm,
        input  aluop, funct, wwd_valid, halted, num_inst
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit
// TSC-subset CPU, with memory ready handshake and retire counter.
module multicycle_control (
    input  logic clk,
    input  logic reset,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'd15;
    localparam logic [3:0] OP_ADI   = 4'd4;
    localparam logic [3:0] OP_LHI   = 4'd6;
    localparam logic [3:0] OP_LWD   = 4'd7;
    localparam logic [3:0] OP_SWD   = 4'd8;
    localparam logic [3:0] OP_JMP   = 4'd9;
    localparam logic [5:0] FN_ADD   = 6'd0;
    localparam logic [5:0] FN_WWD   = 6'd28;
    localparam logic [5:0] FN_HLT   = 6'd29;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] num_q, num_d;
    logic        retire;

    logic [3:0] op;
    logic [5:0] fn;
    logic is_rt, is_add, is_wwd, is_hlt;
    logic is_adi, is_lhi, is_lwd, is_swd, is_jmp;
    logic supported, in_alu;

    assign op     = ir_q[15:12];
    assign fn     = ir_q[5:0];
    assign is_rt  = (op == OP_RTYPE);
    assign is_add = is_rt && (fn == FN_ADD);
    assign is_wwd = is_rt && (fn == FN_WWD);
    assign is_hlt = is_rt && (fn == FN_HLT);
    assign is_adi = (op == OP_ADI);
    assign is_lhi = (op == OP_LHI);
    assign is_lwd = (op == OP_LWD);
    assign is_swd = (op == OP_SWD);
    assign is_jmp = (op == OP_JMP);
    assign supported = is_add | is_wwd | is_hlt | is_adi
                     | is_lhi | is_lwd | is_swd | is_jmp;
    assign in_alu = (state_q == S_EXEC) || (state_q == S_MEM)
                 || (state_q == S_WB);

    always_comb begin
        state_d         = state_q;
        ir_d            = ir_q;
        retire          = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src_jump = 1'b0;
        bus.reg_write   = 1'b0;
        bus.reg_dst_rd  = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.alu_src_imm = 1'b0;
        bus.aluop       = 4'd0;
        bus.funct       = 6'd0;
        bus.wwd_valid   = 1'b0;
        bus.halted      = 1'b0;

        // Loads and stores borrow ADI so the ALU forms the address
        if (in_alu) begin
            bus.aluop       = (is_lwd || is_swd) ? OP_ADI : op;
            bus.funct       = fn;
            bus.alu_src_imm = is_adi | is_lhi | is_lwd | is_swd;
        end

        unique case (state_q)
            S_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    ir_d         = bus.instr;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_hlt) begin
                    retire  = 1'b1;
                    state_d = S_HALT;
                end else if (!supported) begin
                    bus.pc_write = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_wwd) begin
                    bus.wwd_valid = 1'b1;
                    bus.pc_write  = 1'b1;
                    state_d       = S_FETCH;
                end else if (is_jmp) begin
                    bus.pc_src_jump = 1'b1;
                    bus.pc_write    = 1'b1;
                    state_d         = S_FETCH;
                end else if (is_lwd || is_swd) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.mem_read  = is_lwd;
                bus.mem_write = is_swd;
                if (bus.mem_ready) begin
                    if (is_lwd) begin
                        state_d = S_WB;
                    end else begin
                        bus.pc_write = 1'b1;
                        state_d      = S_FETCH;
                    end
                end
            end
            S_WB: begin
                bus.reg_write  = 1'b1;
                bus.pc_write   = 1'b1;
                bus.reg_dst_rd = is_rt;
                bus.mem_to_reg = is_lwd;
                state_d        = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        num_d = num_q;
        if (retire || bus.pc_write) num_d = num_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            ir_q    <= 16'h0000;
            num_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            num_q   <= num_d;
        end
    end

    assign bus.num_inst = num_q;
endmodule
